mux4_1: RTL and testbench

MUX4_1 -- requirements
Module: mux4_1

---
 rtl/mux4_1.sv | 81 ++++++++
 tb/tb_mux4_1.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mux4_1.sv
// -----------------------------------------------------------------------------
// mux4_1 -- 4-to-1 single-bit multiplexer with optional output register.
//
// Build option:
//   MUX4_1_REG_OUT_EN  defined   -> y is registered on rising clk, 1-cycle
//                                   latency, synchronous active-low reset
//                                   loads RESET_VAL.
//                      undefined -> y = data[sel], purely combinational;
//                                   clk/rst_n are present but ignored.
//
// Ports (identical in both builds):
//   clk    in  1  rising-edge clock (registered build only)
//   rst_n  in  1  synchronous active-low reset (registered build only)
//   data   in  4  four 1-bit lanes, lane k is data[k]
//   sel    in  2  lane select 0..3
//   y      out 1  selected lane
// -----------------------------------------------------------------------------

// Per-lane term: passes the lane bit only when sel names this lane, so an
// unselected lane contributes a hard 0 to the OR tree.
module mux4_1_lane #(
  parameter int unsigned LANE  = 0,
  parameter int unsigned SEL_W = 2
) (
  input  logic             data_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             term_o
);
  localparam logic [SEL_W-1:0] CODE = SEL_W'(LANE);

  assign term_o = data_i & (sel_i == CODE);
endmodule

module mux4_1 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data,
  input  logic [1:0] sel,
  output logic       y
);
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  logic [NUM_LANES-1:0] term;
  logic                 y_d;

  // One-hot AND-OR mux: every sel code decodes to exactly one lane.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    mux4_1_lane #(
      .LANE  (k),
      .SEL_W (SEL_W)
    ) u_lane (
      .data_i (data[k]),
      .sel_i  (sel),
      .term_o (term[k])
    );
  end

  assign y_d = |term;

`ifdef MUX4_1_REG_OUT_EN
  logic y_q;

  // Reset wins over the data load; both act only at the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) y_q <= RESET_VAL;
    else        y_q <= y_d;
  end

  assign y = y_q;
`else
  // Clock, reset and reset value are kept on the interface so both builds
  // share one port list; they are deliberately sunk here.
  logic unused_cfg;
  assign unused_cfg = &{1'b0, clk, rst_n, RESET_VAL};

  assign y = y_d;
`endif
endmodule

// File: tb/tb_mux4_1.sv
module tb_mux4_1;
  logic       clk;
  logic       rst_n;
  logic [3:0] data;
  logic [1:0] sel;
  logic       y;

  int errors = 0;
  int checks = 0;

  localparam logic RST_V = 1'b0;

  mux4_1 #(.RESET_VAL(RST_V)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .sel   (sel),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the selected lane is bit number sel of the data word.
  function automatic logic ref_sel(input logic [3:0] d, input logic [1:0] s);
    int unsigned v;
    v = (int'(d) >> int'(s)) % 2;
    return v[0];
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic       exp_q;
    logic [3:0] d;
    rst_n = 1'b1;
    data  = 4'b0000;
    sel   = 2'd0;

`ifndef MUX4_1_REG_OUT_EN
    // Directed basics
    #1;
    sel = 2'd0; data = 4'b0001; #1;
    check("c_sel0_d0001", y, 1'b1);
    data = 4'b1110; #1;
    check("c_sel0_d1110", y, 1'b0);
    // MSB-first packing {a,b,c,d}: sel=3 picks a, sel=0 picks d
    data = 4'b1000; sel = 2'd3; #1;
    check("c_sel3_msb", y, 1'b1);
    sel = 2'd0; #1;
    check("c_sel0_lsb", y, 1'b0);

    // Sweep: lanes toggle with half-periods 6/4/2/1, sel steps every 30
    for (int t = 0; t < 120; t++) begin
      data[0] = 1'(((t / 6) % 2));
      data[1] = 1'(((t / 4) % 2));
      data[2] = 1'(((t / 2) % 2));
      data[3] = 1'((t % 2));
      sel     = 2'(t / 30);
      #1;
      check("c_sweep", y, ref_sel(data, sel));
    end

    // Lane isolation: only data[2] matters when sel=2
    sel = 2'd2;
    for (int i = 0; i < 16; i++) begin
      data = {1'($urandom_range(1)), 1'b1, 2'($urandom_range(3))};
      #1;
      check("c_iso_sel2", y, 1'b1);
    end

    // rst_n and clk have no effect in the combinational build
    data = 4'b0110; sel = 2'd1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("c_rst_noeffect", y, 1'b1);
    @(posedge clk); #1;
    check("c_rst_noeffect2", y, 1'b1);
    rst_n = 1'b1;

    // Random against the reference
    for (int i = 0; i < 200; i++) begin
      data = 4'($urandom);
      sel  = 2'($urandom);
      #1;
      check("c_rand", y, ref_sel(data, sel));
    end
`else
    // Reset for 2 edges with data/sel pointing at a 1
    data = 4'b1111; sel = 2'd3; rst_n = 1'b0;
    @(posedge clk); #1;
    check("r_rst_edge1", y, RST_V);
    @(posedge clk); #1;
    check("r_rst_edge2", y, RST_V);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("r_rst_release_hold", y, RST_V);
    @(posedge clk); #1;
    check("r_first_load", y, 1'b1);

    // sel 1 -> 2 with data=0100
    @(negedge clk); data = 4'b0100; sel = 2'd1;
    @(posedge clk); #1;
    check("r_sel1", y, 1'b0);
    @(negedge clk); sel = 2'd2;
    #1;
    check("r_sel2_before_edge", y, 1'b0);
    @(posedge clk); #1;
    check("r_sel2_loaded", y, 1'b1);
    // Glitch the selected lane between edges
    data[2] = 1'b0; #1;
    check("r_glitch_low", y, 1'b1);
    data[2] = 1'b1; #1;
    check("r_glitch_restore", y, 1'b1);

    // Simultaneous sel+data change: new data at new sel is captured
    @(negedge clk); data = 4'b0010; sel = 2'd1;
    @(posedge clk); #1;
    check("r_simul", y, 1'b1);

    // Mid-stream reset while y=1: holds until the next edge
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("r_midrst_hold", y, 1'b1);
    @(posedge clk); #1;
    check("r_midrst_applied", y, RST_V);
    @(negedge clk); rst_n = 1'b1;

    // Random with one-cycle-latency model and occasional reset
    exp_q = 1'b0;
    @(posedge clk); #1;
    exp_q = ref_sel(data, sel);
    check("r_rand_prime", y, exp_q);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      d     = 4'($urandom);
      data  = d;
      sel   = 2'($urandom);
      rst_n = ($urandom_range(9) != 0);
      exp_q = rst_n ? ref_sel(d, sel) : RST_V;
      // Pre-edge glitch on every lane must not matter once restored
      #1 data = ~d;
      #1 data = d;
      @(posedge clk); #1;
      check("r_rand", y, exp_q);
    end
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so the run always terminates
  initial begin
    #50000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
